seq_divider16: RTL

//  Sequential unsigned restoring divider, 16-bit dividend / 16-bit divisor -> quotient + remainder.

---
 rtl/div_pkg.sv | 21 ++
 rtl/addersubstractor16bit.sv | 44 ++++
 rtl/seq_divider16.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
//   Shared types and constants for the sequential 16-bit divider.
//   - state_t    : controller states (2-bit encoding)
//   - WIDTH_C    : operand width supported by the shared 16-bit adder/subtractor
//   - CNT_W      : width of the iteration counter (counts WIDTH_C-1 down to 0)
//   - DBZ_QUOT_C : quotient reported on divide-by-zero
// -----------------------------------------------------------------------------
package div_pkg;

  localparam int              WIDTH_C    = 16;
  localparam int              CNT_W      = 4;
  localparam logic [WIDTH_C-1:0] DBZ_QUOT_C = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : div_pkg

// File: rtl/addersubstractor16bit.sv
// -----------------------------------------------------------------------------
// addersubstractor16bit
//   16-bit adder/subtractor from the lab ALU.
//   Ports:
//     a, b     in  16  operands
//     s        in  1   1 = signed flag interpretation, 0 = unsigned
//     i        in  1   1 = subtract (a - b), 0 = add (a + b)
//     sum      out 16  result
//     outc     out 1   carry out of bit 15 (for subtract: 1 = no borrow)
//     borrow   out 1   unsigned borrow of a subtraction
//     overflow out 1   signed overflow (s=1) or unsigned carry/borrow (s=0)
//     isvalid  out 1   result fits in 16 bits under the selected interpretation
// -----------------------------------------------------------------------------
module addersubstractor16bit
  import div_pkg::*;
(
  input  logic [WIDTH_C-1:0] a,
  input  logic [WIDTH_C-1:0] b,
  input  logic               s,
  input  logic               i,
  output logic [WIDTH_C-1:0] sum,
  output logic               outc,
  output logic               borrow,
  output logic               overflow,
  output logic               isvalid
);

  logic [WIDTH_C-1:0] b_eff;
  logic [WIDTH_C:0]   full;

  // Subtraction is a + ~b + 1, so the carry-in equals the mode bit.
  assign b_eff = i ? ~b : b;
  assign full  = {1'b0, a} + {1'b0, b_eff} + {{WIDTH_C{1'b0}}, i};

  assign sum    = full[WIDTH_C-1:0];
  assign outc   = full[WIDTH_C];
  assign borrow = i & ~outc;

  // Signed overflow: operands of equal sign producing a result of the other sign.
  assign overflow = s ? ((a[WIDTH_C-1] == b_eff[WIDTH_C-1]) && (sum[WIDTH_C-1] != a[WIDTH_C-1]))
                      : (i ? borrow : outc);
  assign isvalid  = ~overflow;

endmodule : addersubstractor16bit

// File: rtl/seq_divider16.sv
// -----------------------------------------------------------------------------
// seq_divider16
//   Sequential unsigned restoring divider: dividend / divisor -> quotient,
//   remainder. One quotient bit per clock using the shared 16-bit
//   adder/subtractor in subtract mode as the trial subtractor.
//   Ports:
//     clk          in  1      rising-edge clock
//     reset        in  1      asynchronous, active-high reset
//     start        in  1      request, sampled only when busy=0 (IDLE or DONE)
//     dividend     in  WIDTH  numerator, captured on an accepted start
//     divisor      in  WIDTH  denominator, captured on an accepted start
//     busy         out 1      high while iterating (RUN)
//     done         out 1      one-cycle pulse; results valid from this cycle on
//     quotient     out WIDTH  result quotient, held until the next completion
//     remainder    out WIDTH  result remainder, held until the next completion
//     div_by_zero  out 1      set with done when the captured divisor was 0
//   Latency: non-zero divisor -> done 16 edges after the start edge;
//            zero divisor     -> done 1 edge after the start edge.
// -----------------------------------------------------------------------------
module seq_divider16
  import div_pkg::*;
#(
  parameter int               WIDTH    = WIDTH_C,
  parameter logic [WIDTH-1:0] DBZ_QUOT = DBZ_QUOT_C
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  // The trial subtractor is the fixed 16-bit ALU block.
  if (WIDTH != WIDTH_C) begin : g_width_check
    $error("seq_divider16: only WIDTH=16 is supported");
  end

  state_t state_q, state_d;

  logic [WIDTH:0]     r_q;       // partial remainder, one guard bit
  logic [WIDTH-1:0]   q_q;       // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0]   dsr_q;     // captured divisor
  logic [CNT_W-1:0]   cnt_q;     // iterations left after the current one

  logic               accept;
  logic               zero_div;
  logic [WIDTH:0]     sh;
  logic [WIDTH-1:0]   trial;
  logic               trial_outc;
  logic               nb;
  logic [WIDTH:0]     r_next;
  logic [WIDTH-1:0]   q_next;

  // Flags of the shared subtractor and the guard bit of R are not needed here.
  logic               unused_borrow;
  logic               unused_overflow;
  logic               unused_isvalid;
  logic               unused_r_msb;

  assign accept   = start && ((state_q == IDLE) || (state_q == DONE));
  assign zero_div = (divisor == '0);

  // ---------------------------------------------------------------------------
  // One restoring iteration: shift the next dividend bit into R, try to
  // subtract the divisor, keep the difference when it does not borrow.
  // ---------------------------------------------------------------------------
  assign sh = {r_q[WIDTH-1:0], q_q[WIDTH-1]};

  addersubstractor16bit u_trial (
    .a        (sh[WIDTH-1:0]),
    .b        (dsr_q),
    .s        (1'b0),
    .i        (1'b1),
    .sum      (trial),
    .outc     (trial_outc),
    .borrow   (unused_borrow),
    .overflow (unused_overflow),
    .isvalid  (unused_isvalid)
  );

  // outc=1 means sh[15:0] >= divisor; sh[16]=1 means sh exceeds any divisor.
  assign nb     = trial_outc | sh[WIDTH];
  assign r_next = nb ? {1'b0, trial} : sh;
  assign q_next = {q_q[WIDTH-2:0], nb};

  assign unused_r_msb = r_q[WIDTH];

  // ---------------------------------------------------------------------------
  // Controller: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Controller: next state and decoded outputs
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = zero_div ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (cnt_q == '0) state_d = DONE;
      end
      DONE: begin
        done = 1'b1;
        // A start in the DONE cycle is accepted directly (back-to-back).
        if (start) state_d = zero_div ? DONE : RUN;
        else       state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and result registers. Results change only on the edge that
  // enters DONE, so the previous result stays visible during a new run.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q         <= '0;
      q_q         <= '0;
      dsr_q       <= '0;
      cnt_q       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      r_q   <= '0;
      q_q   <= dividend;
      dsr_q <= divisor;
      cnt_q <= CNT_W'(WIDTH - 1);
      if (zero_div) begin
        // No iterations: report the fixed code and pass the dividend through.
        quotient    <= DBZ_QUOT;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end
    end else if (state_q == RUN) begin
      r_q   <= r_next;
      q_q   <= q_next;
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == '0) begin
        quotient    <= q_next;
        remainder   <= r_next[WIDTH-1:0];
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule : seq_divider16
